scan_request_serializer: RTL and testbench

- Consumer end of the SHA-3 scan request bus.
- Captures a request (24-word block template plus 64-bit threshold) when `start` is seen.
- Replays the request as a word-serial 32-bit valid/ready stream, for downstream links or word-serial hashers.
- Accepts at most one request in flight; reports busy and request completion.

---
 rtl/sha3_scan_pkg.sv | 25 ++
 rtl/i_sha3_scan_request_bus.sv | 19 +
 rtl/scan_word_mux.sv | 41 ++++
 rtl/scan_request_serializer.sv | 152 +++++++++++++++
 tb/tb_scan_request_serializer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_scan_pkg.sv
// ---------------------------------------------------------------------------
// sha3_scan_pkg
// Shared types and constants for the SHA-3 scan request path.
//   TEMPLATE_WORDS  : number of 32-bit words in a block template
//   WORD_W          : stream word width
//   THRESHOLD_W     : width of the scan threshold
//   INDEX_W         : width of the word index counter
//   scan_template_t : 24 x 32 block template (packed, word 0 in the low slot)
//   scan_state_t    : serializer state encoding
// ---------------------------------------------------------------------------
package sha3_scan_pkg;

    localparam int TEMPLATE_WORDS = 24;
    localparam int WORD_W         = 32;
    localparam int THRESHOLD_W    = 64;
    localparam int INDEX_W        = 5;

    typedef logic [TEMPLATE_WORDS-1:0][WORD_W-1:0] scan_template_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } scan_state_t;

endpackage

// File: rtl/i_sha3_scan_request_bus.sv
// ---------------------------------------------------------------------------
// i_sha3_scan_request_bus
// Scan request bus between a request producer and its consumer.
//   start         : request strobe / level
//   threshold     : 64-bit difficulty threshold
//   blockTemplate : 24 x 32-bit block template
// Modports: producer (drives everything), consumer (samples everything).
// ---------------------------------------------------------------------------
interface i_sha3_scan_request_bus;
    import sha3_scan_pkg::*;

    logic                   start;
    logic [THRESHOLD_W-1:0] threshold;
    scan_template_t         blockTemplate;

    modport producer (output start, output threshold, output blockTemplate);
    modport consumer (input  start, input  threshold, input  blockTemplate);

endinterface

// File: rtl/scan_word_mux.sv
// ---------------------------------------------------------------------------
// scan_word_mux
// Combinational word selector for the serializer.
//   template  : captured 24-word block template
//   threshold : captured 64-bit threshold
//   index     : word index 0..31 (only 0..25 are meaningful)
//   word      : selected word; template[index] for 0..23, threshold halves
//               at 24/25 in the order set by THRESHOLD_HI_FIRST, 0 above.
// ---------------------------------------------------------------------------
module scan_word_mux
    import sha3_scan_pkg::*;
#(
    parameter int THRESHOLD_HI_FIRST = 0
) (
    input  logic [TEMPLATE_WORDS*WORD_W-1:0] template,
    input  logic [THRESHOLD_W-1:0]           threshold,
    input  logic [INDEX_W-1:0]               index,
    output logic [WORD_W-1:0]                word
);

    localparam int TABLE_WORDS = 2 ** INDEX_W;

    // Full 32-entry table so any 5-bit index selects a defined word.
    logic [WORD_W-1:0] word_table [TABLE_WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < TEMPLATE_WORDS; gi++) begin : g_template
            assign word_table[gi] = template[gi*WORD_W +: WORD_W];
        end
        for (gi = TEMPLATE_WORDS + 2; gi < TABLE_WORDS; gi++) begin : g_unused
            assign word_table[gi] = '0;
        end
    endgenerate

    assign word_table[TEMPLATE_WORDS]   = (THRESHOLD_HI_FIRST != 0) ? threshold[63:32] : threshold[31:0];
    assign word_table[TEMPLATE_WORDS+1] = (THRESHOLD_HI_FIRST != 0) ? threshold[31:0]  : threshold[63:32];

    assign word = word_table[index];

endmodule

// File: rtl/scan_request_serializer.sv
// ---------------------------------------------------------------------------
// scan_request_serializer
// Consumer end of the SHA-3 scan request bus. Captures one request on start
// (while idle, or on the final handshake of the current request) and replays
// it as a 32-bit valid/ready word stream.
// Parameters:
//   EMIT_THRESHOLD     : 1 = 26 words (template + threshold), 0 = 24 words
//   THRESHOLD_HI_FIRST : 0 = threshold[31:0] first, 1 = threshold[63:32] first
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   as             : request bus (consumer modport)
//   out_word       : current stream word
//   out_valid      : out_word is valid
//   out_ready      : downstream accepts the word this cycle
//   out_last       : final word of the request
//   out_index      : index of the current word
//   busy           : a request is captured and not yet fully sent
//   done           : one-cycle pulse after the final word's handshake
//   dropped_starts : (only with SCAN_SERIALIZER_DROP_COUNT_EN) saturating
//                    count of start cycles ignored while sending
// ---------------------------------------------------------------------------
module scan_request_serializer
    import sha3_scan_pkg::*;
#(
    parameter int EMIT_THRESHOLD     = 1,
    parameter int THRESHOLD_HI_FIRST = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    i_sha3_scan_request_bus.consumer       as,
    output logic [WORD_W-1:0]              out_word,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [INDEX_W-1:0]             out_index,
    output logic                           busy,
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
    output logic [15:0]                    dropped_starts,
`endif
    output logic                           done
);

    localparam int                 NWORDS     = (EMIT_THRESHOLD != 0) ? TEMPLATE_WORDS + 2 : TEMPLATE_WORDS;
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NWORDS - 1);

    scan_state_t            state_reg, state_next;
    logic [INDEX_W-1:0]     index_reg, index_next;
    logic                   done_reg, done_next;
    scan_template_t         template_reg;
    logic [THRESHOLD_W-1:0] threshold_reg;

    logic                   send_active;
    logic                   handshake;
    logic                   last_handshake;
    logic                   capture;
    logic [WORD_W-1:0]      mux_word;

    assign send_active    = (state_reg == ST_SEND);
    assign handshake      = send_active & out_ready;
    assign last_handshake = handshake && (index_reg == LAST_INDEX);

    // Next-state logic. A start on the final handshake edge re-arms the
    // stream directly, so out_valid has no gap between requests.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        done_next  = 1'b0;
        capture    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (as.start) begin
                    capture    = 1'b1;
                    state_next = ST_SEND;
                    index_next = '0;
                end
            end
            ST_SEND: begin
                if (last_handshake) begin
                    done_next  = 1'b1;
                    index_next = '0;
                    if (as.start) begin
                        capture = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (handshake) begin
                    index_next = index_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                index_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            index_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            done_reg  <= done_next;
        end
    end

    // Request capture; the bus is not looked at again until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            template_reg  <= '0;
            threshold_reg <= '0;
        end else if (capture) begin
            template_reg  <= as.blockTemplate;
            threshold_reg <= as.threshold;
        end
    end

    scan_word_mux #(
        .THRESHOLD_HI_FIRST (THRESHOLD_HI_FIRST)
    ) u_word_mux (
        .template  (template_reg),
        .threshold (threshold_reg),
        .index     (index_reg),
        .word      (mux_word)
    );

    // Outputs come straight from registers, so they hold during stalls and
    // drop to zero the moment reset asserts.
    assign out_valid = send_active;
    assign busy      = send_active;
    assign out_index = index_reg;
    assign out_last  = send_active && (index_reg == LAST_INDEX);
    assign out_word  = send_active ? mux_word : '0;
    assign done      = done_reg;

`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_reg <= '0;
        end else if (send_active && as.start && !last_handshake && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign dropped_starts = drop_count_reg;
`endif

endmodule

// File: tb/tb_scan_request_serializer.sv
// ---------------------------------------------------------------------------
// tb_scan_request_serializer
// Drives three serializer builds from one request bus and one out_ready:
//   dut 0: 26 words, low threshold half first
//   dut 1: 24 words (template only)
//   dut 2: 26 words, high threshold half first
// Each build is tracked by a request-level model (captured request + word
// position) and compared every cycle. SCAN_SERIALIZER_DROP_COUNT_EN also
// enables checking of dropped_starts.
// ---------------------------------------------------------------------------
module tb_scan_request_serializer;
    import sha3_scan_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;

    i_sha3_scan_request_bus bus ();

    logic [2:0][31:0] ow;
    logic [2:0]       ov;
    logic [2:0]       ol;
    logic [2:0][4:0]  oi;
    logic [2:0]       ob;
    logic [2:0]       od;
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
    logic [2:0][15:0] ods;
`endif

    scan_request_serializer #(.EMIT_THRESHOLD(1), .THRESHOLD_HI_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .as(bus),
        .out_word(ow[0]), .out_valid(ov[0]), .out_ready(rdy), .out_last(ol[0]),
        .out_index(oi[0]), .busy(ob[0]),
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
        .dropped_starts(ods[0]),
`endif
        .done(od[0])
    );

    scan_request_serializer #(.EMIT_THRESHOLD(0), .THRESHOLD_HI_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .as(bus),
        .out_word(ow[1]), .out_valid(ov[1]), .out_ready(rdy), .out_last(ol[1]),
        .out_index(oi[1]), .busy(ob[1]),
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
        .dropped_starts(ods[1]),
`endif
        .done(od[1])
    );

    scan_request_serializer #(.EMIT_THRESHOLD(1), .THRESHOLD_HI_FIRST(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .as(bus),
        .out_word(ow[2]), .out_valid(ov[2]), .out_ready(rdy), .out_last(ol[2]),
        .out_index(oi[2]), .busy(ob[2]),
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
        .dropped_starts(ods[2]),
`endif
        .done(od[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_nw   [3] = '{26, 24, 26};
    bit          m_hi   [3] = '{1'b0, 1'b0, 1'b1};
    bit          m_act  [3];
    bit          m_done [3];
    int          m_pos  [3];
    int          m_drop [3];
    logic [31:0] m_tmpl [3][24];
    logic [63:0] m_thr  [3];

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(int k);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = m_thr[k][31:0];
        hi = m_thr[k][63:32];
        if (m_pos[k] < 24) return m_tmpl[k][m_pos[k]];
        if (m_pos[k] == 24) return m_hi[k] ? hi : lo;
        return m_hi[k] ? lo : hi;
    endfunction

    // One clock edge of the request-level behaviour for build k.
    task automatic model_edge(int k);
        bit was_act;
        bit hs;
        bit last;
        was_act = m_act[k];
        hs      = was_act && rdy;
        last    = hs && (m_pos[k] == m_nw[k] - 1);
        m_done[k] = last;
        if (hs) m_pos[k]++;
        if (last) m_act[k] = 1'b0;
        if (bus.start) begin
            if (!was_act || last) begin
                m_act[k] = 1'b1;
                m_pos[k] = 0;
                for (int j = 0; j < 24; j++) m_tmpl[k][j] = bus.blockTemplate[j];
                m_thr[k] = bus.threshold;
            end else if (m_drop[k] < 65535) begin
                m_drop[k]++;
            end
        end
    endtask

    task automatic check_dut(int k);
        chk("valid", k, 32'(ov[k]), 32'(m_act[k]));
        chk("busy", k, 32'(ob[k]), 32'(m_act[k]));
        chk("done", k, 32'(od[k]), 32'(m_done[k]));
        if (m_act[k]) begin
            chk("word", k, ow[k], exp_word(k));
            chk("index", k, 32'(oi[k]), 32'(m_pos[k]));
            chk("last", k, 32'(ol[k]), 32'(m_pos[k] == m_nw[k] - 1));
        end else begin
            chk("idle_last", k, 32'(ol[k]), 32'd0);
        end
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
        chk("dropped", k, 32'(ods[k]), 32'(m_drop[k]));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            for (int k = 0; k < 3; k++) model_edge(k);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k);
    endtask

    task automatic set_req(logic [31:0] base, logic [63:0] thr);
        for (int j = 0; j < 24; j++) bus.blockTemplate[j] = base + 32'(j);
        bus.threshold = thr;
    endtask

    task automatic scramble_bus();
        for (int j = 0; j < 24; j++) bus.blockTemplate[j] = $urandom;
        bus.threshold = {$urandom, $urandom};
    endtask

    // Advance until build 0 presents word p (bounded).
    task automatic run_until_pos(int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_act[0] && m_pos[0] == p) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("wait_pos", p, 32'(hit), 32'd1);
    endtask

    task automatic reset_models();
        for (int k = 0; k < 3; k++) begin
            m_act[k]  = 1'b0;
            m_done[k] = 1'b0;
            m_pos[k]  = 0;
            m_drop[k] = 0;
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_busy", k, 32'(ob[k]), 32'd0);
            chk("rst_index", k, 32'(oi[k]), 32'd0);
            chk("rst_last", k, 32'(ol[k]), 32'd0);
            chk("rst_done", k, 32'(od[k]), 32'd0);
            chk("rst_word", k, ow[k], 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        rdy       = 1'b0;
        bus.start = 1'b0;
        set_req(32'h0, 64'h0);
        reset_models();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Basic 26/24-word replay, producer scrambles the bus after capture.
        rdy = 1'b1;
        set_req(32'hA5000000, 64'h11223344_55667788);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        scramble_bus();
        chk("first_word", 0, ow[0], 32'hA5000000);
        run_until_pos(23);
        chk("b_word23", 1, ow[1], 32'hA5000017);
        chk("b_last23", 1, 32'(ol[1]), 32'd1);
        chk("a_last23", 0, 32'(ol[0]), 32'd0);
        step();
        chk("a_word24", 0, ow[0], 32'h55667788);
        chk("c_word24", 2, ow[2], 32'h11223344);
        step();
        chk("a_word25", 0, ow[0], 32'h11223344);
        chk("a_last25", 0, 32'(ol[0]), 32'd1);
        step();
        chk("a_done", 0, 32'(od[0]), 32'd1);
        for (int i = 0; i < 3; i++) step();

        // Stalls with out_ready pattern 1,0,0,1.
        set_req(32'hA5000000, 64'h11223344_55667788);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 200 && (m_act[0] || m_act[2]); c++) begin
            rdy = ((c % 4) == 0) || ((c % 4) == 3);
            step();
        end
        chk("stall_complete", 0, 32'(m_act[0]), 32'd0);
        rdy = 1'b1;
        step();

        // Back-to-back request on the final handshake.
        set_req(32'hA5000000, 64'h11223344_55667788);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_until_pos(25);
        set_req(32'hA5000100, 64'hCAFEF00D_DEADBEEF);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("b2b_valid", 0, 32'(ov[0]), 32'd1);
        chk("b2b_word", 0, ow[0], 32'hA5000100);
        chk("b2b_index", 0, 32'(oi[0]), 32'd0);
        chk("b2b_done", 0, 32'(od[0]), 32'd1);

        // Stray starts during SEND are ignored.
        reset_models();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        set_req(32'hB0000000, 64'h01234567_89ABCDEF);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_until_pos(5);
        scramble_bus();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_until_pos(12);
        scramble_bus();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
`ifdef SCAN_SERIALIZER_DROP_COUNT_EN
        chk("drop_two", 0, 32'(ods[0]), 32'd2);
`endif
        run_until_pos(20);
        chk("stray_word20", 0, ow[0], 32'hB0000014);
        for (int i = 0; i < 8; i++) step();

        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            rdy       = ($urandom_range(0, 3) != 0);
            bus.start = ($urandom_range(0, 11) == 0);
            scramble_bus();
            step();
        end
        bus.start = 1'b0;
        rdy = 1'b1;

        // Reset mid-stream.
        for (int i = 0; i < 40 && m_act[0]; i++) step();
        set_req(32'hC0000000, 64'h0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_until_pos(10);
        #2 rst_n = 1'b0;
        #1;
        reset_models();
        check_reset_outputs();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("post_rst_idle", 0, 32'(ov[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
